intra4x4_mode_sched: RTL
========================

# intra4x4_mode_sched

Sequencer and mode-decision controller for the 4x4 luma intra-prediction SAD unit. For one macroblock it walks the 16 4x4 blocks in coding order, and for each block it enables the SAD datapath and captures the eight per-mode SADs. It then selects the cheapest permitted mode with a sequential comparator and hands the decision to the downstream mode-coding stage over a valid/ready handshake. It sits between the macroblock-level intra control and the SAD unit, and it owns the only enable into that unit.

## Interface
Parameters:
- SAD_W, 12, width of each per-mode SAD value.
- MPM_PENALTY, 4, cost added to non-MPM modes when the MPM bias feature is compiled in.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a macroblock; accepted only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE on the next edge.
- busy  out  1  high in every state except IDLE.
- sad_en  out  1  one-cycle pulse requesting SADs for block blk_idx.
- blk_idx  out  4  current 4x4 block index, 0..15.
- sad_vld  in  1  SAD unit result valid; sampled only in WAIT.
- sad_in  in  8*SAD_W  packed SADs; slice m holds mode index m. Index order: 0 V, 1 H, 2 VL, 3 VR, 4 HU, 5 HD, 6 DDL, 7 DDR.
- avail  in  8  per-block mode-enable mask, bit m enables index m; sampled with sad_vld.
- mpm  in  4  H.264 most-probable mode for the block; sampled with sad_vld.
- mode_vld  out  1  decision valid.
- mode_rdy  in  1  downstream accepts the decision.
- mode_out  out  4  H.264 mode number of the winner.
- best_sad  out  SAD_W  cost of the winner, penalty included.
- done  out  1  one-cycle pulse after block 15 is accepted.
- total_cost  out  SAD_W+4  sum of the 16 best_sad values; stable from done until the next start.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CMP, OUT, DONE.
- IDLE: on start, clear blk_idx and total_cost, then go to ISSUE.
- ISSUE: assert sad_en for one cycle, then go to WAIT.
- WAIT: hold until sad_vld. On sad_vld, capture sad_in, avail and mpm, and go to CMP. An unbounded wait is legal.
- CMP: runs exactly 8 cycles, m = 0..7, one mode per cycle.
  - The running minimum starts at all-ones with found = 0.
  - Mode m is skipped when avail[m] = 0.
  - Otherwise mode m replaces the minimum when its cost is strictly less than the current minimum, or when found = 0.
  - Ties therefore keep the lower index.
- Index to H.264 mode mapping: 0→0, 1→1, 2→7, 3→5, 4→8, 5→6, 6→3, 7→4.
- If avail = 0, the result is mode_out = 2 (DC) and best_sad = all-ones.
- OUT: mode_vld is held high along with stable mode_out and best_sad. On mode_vld && mode_rdy, best_sad is added to total_cost.
  - If blk_idx == 15, go to DONE.
  - Otherwise increment blk_idx and go to ISSUE.
- DONE: pulse done for one cycle, then go to IDLE.
- abort in any state: go to IDLE, drop mode_vld and sad_en, and hold total_cost. abort has priority over every other transition.
- start while busy is ignored.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE.
- start at edge T gives sad_en high during cycle T+1, with blk_idx = 0.
- sad_vld seen at edge W gives CMP during cycles W+1..W+8 and mode_vld high from cycle W+9.
- Minimum per-block period is 11 cycles: ISSUE 1, WAIT 1, CMP 8, OUT 1.
- The next sad_en follows in the cycle after the mode_vld && mode_rdy handshake.
- done is asserted the cycle after the block-15 handshake; total_cost is valid in that cycle.
- sad_vld outside WAIT is ignored and does not advance the FSM.
- Asserting reset mid-macroblock clears all state immediately, with no done pulse.

## Configuration
- INTRA4X4_MPM_BIAS_EN defined: the cost of mode m is sad + MPM_PENALTY when map(m) != mpm, otherwise sad. The add saturates at 2^SAD_W−1.
- INTRA4X4_MPM_BIAS_EN undefined: cost is the raw sad, and the mpm input is ignored.

## Test plan
- All avail = 1, SADs {40,30,50,30,60,70,80,90}, mode_rdy = 1, macro off -> mode_out = 1 (H), best_sad = 30; the tie with index 3 is lost. 16 identical blocks -> done with total_cost = 480.
- avail = 8'b0000_0100, SADs all 10 -> mode_out = 7 (VL), best_sad = 10. avail = 0 -> mode_out = 2, best_sad = 4095.
- sad_vld delayed 5 cycles and mode_rdy held low for 3 cycles -> sad_en occurs once per block, mode_vld and its data stay stable while stalled, and the block period is 19 cycles.
- Macro on, MPM_PENALTY = 4, mpm = 0, SADs {33,30,...} with all others 99 -> mode_out = 0, best_sad = 33 (H cost 34). With SAD_W = 12, a sad of 4094 on a non-MPM mode is costed at 4095.
- abort asserted during CMP of block 7 -> busy = 0 next cycle, no done, total_cost holds the sum of blocks 0..6. A following start restarts at blk_idx = 0.
- reset asserted asynchronously while in OUT -> mode_vld, busy and total_cost drop to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/intra4x4_mode_sched_if.sv
// intra4x4_mode_sched_if: control, SAD-unit and mode-decision signals of the 4x4 intra scheduler.
// master is the scheduler side, slave is the environment driving it.
interface intra4x4_mode_sched_if #(
    parameter int SAD_W = 12
);
    logic                 start;
    logic                 abort;
    logic                 busy;
    logic                 sad_en;
    logic [3:0]           blk_idx;
    logic                 sad_vld;
    logic [8*SAD_W-1:0]   sad_in;
    logic [7:0]           avail;
    logic [3:0]           mpm;
    logic                 mode_vld;
    logic                 mode_rdy;
    logic [3:0]           mode_out;
    logic [SAD_W-1:0]     best_sad;
    logic                 done;
    logic [SAD_W+3:0]     total_cost;

    modport master (
        input  start, abort, sad_vld, sad_in, avail, mpm, mode_rdy,
        output busy, sad_en, blk_idx, mode_vld, mode_out, best_sad, done, total_cost
    );

    modport slave (
        output start, abort, sad_vld, sad_in, avail, mpm, mode_rdy,
        input  busy, sad_en, blk_idx, mode_vld, mode_out, best_sad, done, total_cost
    );
endinterface

// File: rtl/intra4x4_mode_sched.sv
// intra4x4_mode_sched: walks 16 4x4 blocks, captures 8 mode SADs each and picks the cheapest permitted mode.
// Defining INTRA4X4_MPM_BIAS_EN adds a saturating MPM_PENALTY to every non-MPM mode cost.
module intra4x4_mode_sched #(
    parameter int SAD_W       = 12,
    parameter int MPM_PENALTY = 4
) (
    input logic clk,
    input logic reset,
    intra4x4_mode_sched_if.master bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CMP, OUT, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         blk_q, blk_d;
    logic [SAD_W+3:0]   total_q, total_d;
    logic [8*SAD_W-1:0] sad_q, sad_d;
    logic [7:0]         avail_q, avail_d;
    logic [2:0]         m_q, m_d, idx_q, idx_d;
    logic [SAD_W-1:0]   min_q, min_d, best_q, best_d;
    logic               found_q, found_d;
    logic [3:0]         mode_q, mode_d;
    logic [SAD_W-1:0]   sad_m, cost;
    logic               take;

    function automatic logic [3:0] h264_mode(input logic [2:0] i);
        case (i)
            3'd2:    return 4'd7;
            3'd3:    return 4'd5;
            3'd4:    return 4'd8;
            3'd5:    return 4'd6;
            3'd6:    return 4'd3;
            3'd7:    return 4'd4;
            default: return {1'b0, i};
        endcase
    endfunction

    assign sad_m = sad_q[m_q*SAD_W +: SAD_W];

`ifdef INTRA4X4_MPM_BIAS_EN
    logic [3:0]     mpm_q, mpm_d;
    logic [SAD_W:0] pen_sum;
    assign pen_sum = {1'b0, sad_m} + (SAD_W+1)'(MPM_PENALTY);
    assign cost    = (h264_mode(m_q) == mpm_q) ? sad_m : (pen_sum[SAD_W] ? '1 : pen_sum[SAD_W-1:0]);
`else
    assign cost = sad_m;
`endif

    // First permitted mode always wins; afterwards only a strictly lower cost does, so ties keep the lower index.
    assign take = avail_q[m_q] && (!found_q || cost < min_q);

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        total_d = total_q;
        sad_d   = sad_q;
        avail_d = avail_q;
        m_d     = m_q;
        idx_d   = idx_q;
        min_d   = min_q;
        found_d = found_q;
        best_d  = best_q;
        mode_d  = mode_q;
`ifdef INTRA4X4_MPM_BIAS_EN
        mpm_d   = mpm_q;
`endif
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    state_d = ISSUE;
                    blk_d   = '0;
                    total_d = '0;
                end
                ISSUE: state_d = WAIT;
                WAIT: if (bus.sad_vld) begin
                    state_d = CMP;
                    sad_d   = bus.sad_in;
                    avail_d = bus.avail;
`ifdef INTRA4X4_MPM_BIAS_EN
                    mpm_d   = bus.mpm;
`endif
                    m_d     = '0;
                    min_d   = '1;
                    found_d = 1'b0;
                end
                CMP: begin
                    if (take) begin
                        min_d   = cost;
                        idx_d   = m_q;
                        found_d = 1'b1;
                    end
                    m_d = m_q + 3'd1;
                    if (m_q == 3'd7) begin
                        state_d = OUT;
                        best_d  = min_d;
                        mode_d  = found_d ? h264_mode(idx_d) : 4'd2;
                    end
                end
                OUT: if (bus.mode_rdy) begin
                    total_d = total_q + {4'b0, best_q};
                    state_d = (blk_q == 4'd15) ? DONE : ISSUE;
                    blk_d   = (blk_q == 4'd15) ? blk_q : blk_q + 4'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            blk_q   <= '0;
            total_q <= '0;
            sad_q   <= '0;
            avail_q <= '0;
            m_q     <= '0;
            idx_q   <= '0;
            min_q   <= '0;
            found_q <= 1'b0;
            best_q  <= '0;
            mode_q  <= '0;
`ifdef INTRA4X4_MPM_BIAS_EN
            mpm_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            total_q <= total_d;
            sad_q   <= sad_d;
            avail_q <= avail_d;
            m_q     <= m_d;
            idx_q   <= idx_d;
            min_q   <= min_d;
            found_q <= found_d;
            best_q  <= best_d;
            mode_q  <= mode_d;
`ifdef INTRA4X4_MPM_BIAS_EN
            mpm_q   <= mpm_d;
`endif
        end
    end

    assign bus.busy       = state_q != IDLE;
    assign bus.sad_en     = state_q == ISSUE;
    assign bus.mode_vld   = state_q == OUT;
    assign bus.done       = state_q == DONE;
    assign bus.blk_idx    = blk_q;
    assign bus.mode_out   = mode_q;
    assign bus.best_sad   = best_q;
    assign bus.total_cost = total_q;
endmodule
